// File: rtl/exec_stage_if.sv
// exec_stage_if: issue bus from the decoder into the execute stage.
// Carries in_valid/in_ready handshake, op, rd and both register operands.
interface exec_stage_if #(
   parameter int W = 8,
   parameter int N = 5
);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [N-1:0] rd;
   logic [W-1:0] rdata1;
   logic [W-1:0] rdata2;

   modport master (
      output in_valid, op, rd, rdata1, rdata2,
      input  in_ready
   );

   modport slave (
      input  in_valid, op, rd, rdata1, rdata2,
      output in_ready
   );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: execute stage of the 8-bit RISC datapath (ALU + optional MUL).
// Ports: clk, reset (sync, active-low); issue (exec_stage_if.slave:
// in_valid/in_ready, op, rd, rdata1, rdata2); write-back write/wreg/wdata;
// flags zero/carry. Define EXEC_MUL_EN to build the W-cycle shift-add MUL.
module exec_stage #(
   parameter int W = 8,
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         reset,
   exec_stage_if.slave  issue,
   output logic         write,
   output logic [N-1:0] wreg,
   output logic [W-1:0] wdata,
   output logic         zero,
   output logic         carry
);
   localparam int SW = (W > 1) ? $clog2(W) : 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [SW-1:0] amt;
   logic [W:0]    sum;
   logic [W:0]    dif;
   logic [W:0]    shl_w;
   logic [W:0]    shr_w;
   logic [W-1:0]  alu_res;
   logic          alu_c;
   logic          fire;
   logic          idle;
   logic          is_add, is_sub, is_and, is_or;
   logic          is_xor, is_shl, is_shr, is_mul;

   assign a   = issue.rdata1;
   assign b   = issue.rdata2;
   assign amt = b[SW-1:0];

   assign sum = {1'b0, a} + {1'b0, b};
   // borrow lands in the extra top bit
   assign dif = {1'b0, a} - {1'b0, b};
   // extra bit catches the last bit shifted out; stays 0 for amt == 0
   assign shl_w = {1'b0, a} << amt;
   assign shr_w = {a, 1'b0} >> amt;

   assign is_add = (issue.op == OP_ADD);
   assign is_sub = (issue.op == OP_SUB);
   assign is_and = (issue.op == OP_AND);
   assign is_or  = (issue.op == OP_OR);
   assign is_xor = (issue.op == OP_XOR);
   assign is_shl = (issue.op == OP_SHL);
   assign is_shr = (issue.op == OP_SHR);
   assign is_mul = (issue.op == OP_MUL);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      unique case (1'b1)
         is_add: begin
            alu_res = sum[W-1:0];
            alu_c   = sum[W];
         end
         is_sub: begin
            alu_res = dif[W-1:0];
            alu_c   = dif[W];
         end
         is_and: alu_res = a & b;
         is_or:  alu_res = a | b;
         is_xor: alu_res = a ^ b;
         is_shl: begin
            alu_res = shl_w[W-1:0];
            alu_c   = shl_w[W];
         end
         is_shr: begin
            alu_res = shr_w[W:1];
            alu_c   = shr_w[0];
         end
         is_mul: ;
         default: ;
      endcase
   end

   assign fire = issue.in_valid & issue.in_ready;

`ifdef EXEC_MUL_EN
   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [SW-1:0]  cnt;
   logic [2*W-1:0] mcand;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_nxt;
   logic [W-1:0]   mplier;
   logic [N-1:0]   mrd;
   logic           mul_load;
   logic           mul_step;
   logic           mul_done;

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // IDLE implies in_ready, so in_valid alone qualifies the load
   always_comb begin
      state_nxt = state;
      mul_load  = 1'b0;
      mul_step  = 1'b0;
      mul_done  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (issue.in_valid && is_mul) begin
               mul_load  = 1'b1;
               state_nxt = S_MUL;
            end
         end
         S_MUL: begin
            mul_step = 1'b1;
            if (cnt == SW'(W - 1)) begin
               mul_done  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // multiplicand walks left, multiplier walks right, one bit per edge
   assign acc_nxt = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         mrd    <= '0;
      end else if (mul_load) begin
         cnt    <= '0;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         mrd    <= issue.rd;
      end else if (mul_step) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= mul_done ? '0 : cnt + 1'b1;
      end
   end

   assign idle = (state == S_IDLE);
`else
   assign idle = 1'b1;
`endif

   assign issue.in_ready = reset & idle;

   // op 111 never writes directly: it is either the MUL start or a NOP
   always_ff @(posedge clk) begin
      if (!reset) begin
         write <= 1'b0;
         wreg  <= '0;
         wdata <= '0;
         zero  <= 1'b0;
         carry <= 1'b0;
      end else begin
         write <= 1'b0;
         if (fire && !is_mul) begin
            write <= 1'b1;
            wreg  <= issue.rd;
            wdata <= alu_res;
            zero  <= (alu_res == '0);
            carry <= alu_c;
         end
`ifdef EXEC_MUL_EN
         else if (mul_done) begin
            write <= 1'b1;
            wreg  <= mrd;
            wdata <= acc_nxt[W-1:0];
            zero  <= (acc_nxt[W-1:0] == '0);
            carry <= |acc_nxt[2*W-1:W];
         end
`endif
      end
   end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed + random bench for exec_stage.
// Reference model is cycle-count based integer arithmetic.
module tb_exec_stage;
   localparam int W = 8;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         write;
   logic [N-1:0] wreg;
   logic [W-1:0] wdata;
   logic         zero;
   logic         carry;

   exec_stage_if #(.W(W), .N(N)) bus();

   exec_stage #(.W(W), .N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .issue (bus),
      .write (write),
      .wreg  (wreg),
      .wdata (wdata),
      .zero  (zero),
      .carry (carry)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   int m_write, m_wreg, m_wdata, m_zero, m_carry;
   int busy;
   int p_rd, p_res, p_c;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic ref_op(input int o, input int x, input int y,
                         output int res, output int c);
      int sh;
      sh = y % 8;
      c  = 0;
      case (o)
         0: begin res = (x + y) % 256; c = (x + y > 255); end
         1: begin res = (x - y + 256) % 256; c = (x < y); end
         2: res = x & y;
         3: res = x | y;
         4: res = x ^ y;
         5: begin
            res = (x * (1 << sh)) % 256;
            c   = (sh == 0) ? 0 : (x >> (8 - sh)) & 1;
         end
         6: begin
            res = x >> sh;
            c   = (sh == 0) ? 0 : (x >> (sh - 1)) & 1;
         end
         default: begin res = (x * y) % 256; c = (x * y > 255); end
      endcase
   endtask

   task automatic model_edge(input int r, input int v, input int o,
                             input int d, input int x, input int y);
      int res, c;
      if (r == 0) begin
         m_write = 0; m_wreg = 0; m_wdata = 0;
         m_zero = 0; m_carry = 0; busy = 0;
      end else begin
         m_write = 0;
         if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               m_write = 1; m_wreg = p_rd; m_wdata = p_res;
               m_zero = (p_res == 0); m_carry = p_c;
            end
         end else if (v != 0) begin
            ref_op(o, x, y, res, c);
            if (o == 7) begin
`ifdef EXEC_MUL_EN
               busy = W; p_rd = d; p_res = res; p_c = c;
`endif
            end else begin
               m_write = 1; m_wreg = d; m_wdata = res;
               m_zero = (res == 0); m_carry = c;
            end
         end
      end
   endtask

   // called at a negedge: drive, check ready, clock, check outputs
   task automatic step(input int r, input int v, input int o,
                       input int d, input int x, input int y);
      reset        = r[0];
      bus.in_valid = v[0];
      bus.op       = o[2:0];
      bus.rd       = d[N-1:0];
      bus.rdata1   = x[W-1:0];
      bus.rdata2   = y[W-1:0];
      #1;
      check("in_ready", bus.in_ready, (r != 0 && busy == 0) ? 1 : 0);
      @(posedge clk);
      model_edge(r, v, o, d, x, y);
      @(negedge clk);
      check("write", write, m_write);
      check("wreg", wreg, m_wreg);
      check("wdata", wdata, m_wdata);
      check("zero", zero, m_zero);
      check("carry", carry, m_carry);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lows;
      m_write = 0; m_wreg = 0; m_wdata = 0;
      m_zero = 0; m_carry = 0; busy = 0;
      p_rd = 0; p_res = 0; p_c = 0;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.op = '0; bus.rd = '0;
      bus.rdata1 = '0; bus.rdata2 = '0;

      repeat (2) begin
         step(0, 1, 0, 1, 1, 2);
         check("rst_write", write, 0);
         check("rst_wdata", wdata, 0);
         check("rst_zero", zero, 0);
         check("rst_carry", carry, 0);
         check("rst_ready", bus.in_ready, 0);
      end
      step(1, 0, 0, 0, 0, 0);
      check("rel_ready", bus.in_ready, 1);

      step(1, 1, 0, 7, 200, 100);
      check("add_write", write, 1);
      check("add_wreg", wreg, 7);
      check("add_wdata", wdata, 44);
      check("add_carry", carry, 1);
      check("add_zero", zero, 0);
      step(1, 0, 0, 0, 0, 0);
      check("add_once", write, 0);

      step(1, 1, 1, 3, 5, 5);
      check("sub_write", write, 1);
      check("sub_wreg", wreg, 3);
      check("sub_wdata", wdata, 0);
      check("sub_zero", zero, 1);
      check("sub_carry", carry, 0);
      step(1, 1, 4, 4, 'hF0, 'h0F);
      check("xor_write", write, 1);
      check("xor_wreg", wreg, 4);
      check("xor_wdata", wdata, 'hFF);
      check("xor_zero", zero, 0);
      step(1, 0, 0, 0, 0, 0);

      step(1, 1, 5, 1, 'h81, 1);
      check("shl_wdata", wdata, 'h02);
      check("shl_carry", carry, 1);
      step(1, 1, 6, 2, 'h81, 0);
      check("shr0_wdata", wdata, 'h81);
      check("shr0_carry", carry, 0);
      step(1, 1, 6, 3, 'h01, 1);
      check("shr1_wdata", wdata, 0);
      check("shr1_zero", zero, 1);
      check("shr1_carry", carry, 1);
      step(1, 0, 0, 0, 0, 0);

`ifdef EXEC_MUL_EN
      lows = 0;
      step(1, 1, 7, 31, 13, 11);
      if (!bus.in_ready) lows++;
      for (int i = 0; i < W; i++) begin
         step(1, 1, 0, 1, 1, 1);
         if (!bus.in_ready) lows++;
      end
      check("mul_stall", lows, 8);
      check("mul_write", write, 1);
      check("mul_wreg", wreg, 31);
      check("mul_wdata", wdata, 'h8F);
      check("mul_carry", carry, 0);
      step(1, 1, 7, 2, 20, 20);
      for (int i = 0; i < W; i++) step(1, 0, 0, 0, 0, 0);
      check("mul2_wdata", wdata, 'h90);
      check("mul2_carry", carry, 1);
      step(1, 0, 0, 0, 0, 0);
`else
      step(1, 1, 7, 9, 13, 11);
      check("nop_write", write, 0);
      check("nop_ready", bus.in_ready, 1);
      check("nop_carry", carry, 1);
`endif

      step(1, 1, 7, 31, 13, 11);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("abort_ready", bus.in_ready, 1);
      lows = 0;
      for (int i = 0; i < 2 * W; i++) begin
         step(1, 0, 0, 0, 0, 0);
         if (write) lows++;
      end
      check("abort_nowrite", lows, 0);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 39) != 0) ? 1 : 0,
              ($urandom_range(0, 9) < 7) ? 1 : 0,
              $urandom_range(0, 7), $urandom_range(0, 31),
              $urandom_range(0, 255), $urandom_range(0, 255));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the 8-bit RISC datapath, directly downstream of the register file. Takes the two operands read from the register file plus a decoded opcode and destination index, computes the result, and drives it back into the register file's write port as a one-cycle write pulse. Single-cycle ALU ops stream at one per cycle. An optional multi-cycle shift-add multiplier stalls the upstream decoder through a valid/ready handshake.

## Interface
Parameters:
- `W`, default 8: data width; must match register file `W`.
- `N`, default 5: register index width; must match register file `N`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `in_valid`, in, 1: decoder presents an operation this cycle.
- `in_ready`, out, 1: stage can accept an operation. A transfer occurs on an edge where `in_valid && in_ready`.
- `op`, in, 3: opcode; see Operation.
- `rd`, in, N: destination register index.
- `rdata1`, in, W: operand A, from register file `rdata1`.
- `rdata2`, in, W: operand B, from register file `rdata2`.
- `write`, out, 1: register file write enable; one-cycle pulse per result.
- `wreg`, out, N: register file write index.
- `wdata`, out, W: register file write data.
- `zero`, out, 1: flag; last written result equals 0.
- `carry`, out, 1: flag; carry, borrow, shift-out or overflow of the last result.

## Operation
- Opcodes:
  - 000 ADD: `wdata = A+B` mod 2^W; `carry` = carry-out.
  - 001 SUB: `wdata = A-B` mod 2^W; `carry` = 1 iff A < B (unsigned).
  - 010 AND, 011 OR, 100 XOR: `carry` = 0.
  - 101 SHL: shift A left by `B[$clog2(W)-1:0]`; `carry` = last bit shifted out, 0 if the shift amount is 0.
  - 110 SHR: logical shift right, same amount and carry rule as SHL.
  - 111 MUL: `wdata` = low W bits of A*B; `carry` = 1 iff the high W bits are nonzero.
- `zero` = (`wdata` == 0) for every written result.
- `zero` and `carry` update only on the edge that asserts `write`. They hold their value otherwise.
- No hardwired-zero register: `rd` = 0 is written like any other index.
- FSM states:
  - IDLE: `in_ready` = 1.
    - Accepted non-MUL op: the result registers on the same edge and `write` = 1 for the following cycle; the state stays IDLE.
    - Accepted MUL: latch A, B and `rd`, clear the accumulator, set `cnt` = 0, go to MUL.
  - MUL: `in_ready` = 0. Each edge performs one shift-add iteration and increments `cnt`. On the edge where `cnt` == W-1, the final product registers, `write` = 1 and the state returns to IDLE.
- `write` deasserts on any edge that does not register a new result.
- `wreg` and `wdata` hold their last value when `write` = 0.
- `in_ready` is forced to 0 while `reset` = 0.

## Timing
- Reset: on an edge with `reset` = 0, the following are cleared:
  - state to IDLE
  - `write`, `wreg`, `wdata`, `zero`, `carry`, `cnt` to 0
- Reset mid-MUL aborts the multiply; no write is ever issued for it.
- Non-MUL latency: accept on edge E0, `write` high from E0 to E1. The register file captures the result at E1.
- Throughput: one non-MUL op per cycle with no bubbles.
- MUL latency: accept at E0, `write` high for one cycle after E(W).
  - `in_ready` is low from E0 to E(W).
  - The next op can be accepted at E(W+1).
- Inputs are sampled only on the transfer edge. `rdata1`, `rdata2` and `rd` may change freely afterwards.
- `in_valid` = 0 in IDLE: no state change and no write.

## Configuration
- `EXEC_MUL_EN` defined: opcode 111 performs the multi-cycle MUL described above.
- `EXEC_MUL_EN` undefined: the MUL state, multiplier and `cnt` are not synthesised.
  - Opcode 111 is accepted as a NOP with `in_ready` remaining 1.
  - No write is issued and the flags are unchanged.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with `in_valid` = 1, `op` = ADD.
  - During reset: `write` = 0, `wdata` = 0, `zero` = 0, `carry` = 0, `in_ready` = 0.
  - `in_ready` = 1 after release.
- ADD: 200 + 100, `rd` = 7 → exactly one `write` pulse in the next cycle, `wreg` = 7, `wdata` = 44, `carry` = 1, `zero` = 0.
- Back-to-back ops on consecutive edges:
  - SUB 5-5, `rd` = 3 → write (3, 0), `zero` = 1, `carry` = 0.
  - XOR 0xF0^0x0F, `rd` = 4 → write (4, 0xFF), `zero` = 0.
  - The two writes occur on consecutive cycles.
- Shifts:
  - SHL 0x81 by 1 → 0x02, `carry` = 1.
  - SHR 0x81 by 0 → 0x81, `carry` = 0.
  - SHR 0x01 by 1 → 0x00, `zero` = 1, `carry` = 1.
- MUL (`EXEC_MUL_EN`):
  - 13×11, `rd` = 31 → `in_ready` low for 8 cycles, `write` asserted one cycle after edge E8, `wdata` = 0x8F, `carry` = 0.
  - 20×20 → 0x90, `carry` = 1.
  - Without the macro: op 111 causes no write and `in_ready` stays 1.
- Reset mid-MUL: assert `reset` = 0 four cycles after accepting 13×11 → no write is ever issued, and `in_ready` = 1 on the first cycle after release.
